// File: rtl/sword_attack_ctrl.sv
// rtl/sword_attack_ctrl.sv - sword swing animation sequencer and sprite ROM addressing
module sword_attack_ctrl #(
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int FRAMES      = 3,
    parameter int HOLD_FRAMES = 4,
    parameter int COOLDOWN    = 8
) (
    input  logic        vga_clk,
    input  logic        Reset,
    input  logic        attack_req,
    input  logic        flip_h,
    input  logic [9:0]  sword_x,
    input  logic [9:0]  sword_y,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    output logic        busy,
    output logic [1:0]  frame_sel,
    output logic [11:0] rom_address,
    output logic        sprite_hit,
    output logic        attack_done
);

    localparam int COL_W  = $clog2(SPRITE_W);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    typedef enum logic [1:0] {IDLE, SWING, COOL} state_t;

    state_t              state_q, state_d;
    logic [1:0]          frame_q, frame_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [COOL_W-1:0]   cool_q, cool_d;
    logic                flip_q, flip_d;
    logic [9:0]          sx_q, sx_d, sy_q, sy_d;
    logic                done_q, done_d;
    logic [11:0]         addr_q, addr_d;
    logic                hit1_q, hit1_d, hit2_q;

    logic                in_x, in_y, in_box;
    logic [COL_W-1:0]    col, col_f;
    logic [ROW_W-1:0]    row;

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            frame_q <= '0;
            hold_q  <= '0;
            cool_q  <= '0;
            flip_q  <= 1'b0;
            sx_q    <= '0;
            sy_q    <= '0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            hit1_q  <= 1'b0;
            hit2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            cool_q  <= cool_d;
            flip_q  <= flip_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            hit1_q  <= hit1_d;
            hit2_q  <= hit1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        cool_d  = cool_q;
        flip_d  = flip_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A frame_start coinciding with the accept is deliberately not counted
                if (attack_req) begin
                    state_d = SWING;
                    frame_d = '0;
                    hold_d  = '0;
                    flip_d  = flip_h;
                    sx_d    = sword_x;
                    sy_d    = sword_y;
                end
            end
            SWING: begin
                if (frame_start) begin
                    sx_d = sword_x;
                    sy_d = sword_y;
                    if (hold_q != HOLD_W'(HOLD_FRAMES - 1)) begin
                        hold_d = hold_q + 1'b1;
                    end else if (frame_q != 2'(FRAMES - 1)) begin
                        frame_d = frame_q + 2'd1;
                        hold_d  = '0;
                    end else begin
                        state_d = COOL;
                        done_d  = 1'b1;
                        cool_d  = '0;
                        frame_d = '0;
                        hold_d  = '0;
                    end
                end
            end
            COOL: begin
                if (frame_start) begin
                    if (cool_q == COOL_W'(COOLDOWN - 1)) begin
                        state_d = IDLE;
                        cool_d  = '0;
                    end else begin
                        cool_d = cool_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Upper bound compared in 11 bits so a sprite near the right edge never wraps
    always_comb begin
        in_x   = (DrawX >= sx_q) && ({1'b0, DrawX} < ({1'b0, sx_q} + 11'(SPRITE_W)));
        in_y   = (DrawY >= sy_q) && ({1'b0, DrawY} < ({1'b0, sy_q} + 11'(SPRITE_H)));
        in_box = in_x && in_y && blank && (state_q == SWING);
        col    = DrawX[COL_W-1:0] - sx_q[COL_W-1:0];
        col_f  = flip_q ? ~col : col;
        row    = DrawY[ROW_W-1:0] - sy_q[ROW_W-1:0];
        addr_d = in_box ? {frame_q, row, col_f} : '0;
        hit1_d = in_box;
    end

    assign busy        = (state_q != IDLE);
    assign frame_sel   = frame_q;
    assign rom_address = addr_q;
    assign sprite_hit  = hit2_q;
    assign attack_done = done_q;

endmodule
